spi_slave_i: RTL and testbench

Receive-only SPI responder for the measurement unit: the input-side counterpart of the write-only DAC SPI master. It oversamples an external SCLK/MOSI/SYNC bus (AD5300-style framing: SYNC active-low, MSB first, data sampled on SCLK falling edge) in the system clock domain. It delivers each complete DATA_WIDTH-bit frame as a parallel word with a one-cycle valid strobe. Malformed frames are rejected with an error strobe.

---
 rtl/spi_slave_i.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave_i.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_i.sv
// rtl/spi_slave_i.sv - receive-only SPI responder (SYNC active-low, MSB first, sample on SCLK fall)
//
// Ports:
//   clk_i   in   system clock, all logic on rising edge
//   rst_i   in   synchronous active-high reset
//   sclk_i  in   SPI serial clock (asynchronous)
//   mosi_i  in   SPI serial data (asynchronous)
//   sync_i  in   frame select, active low (asynchronous)
//   data_o  out  last good DATA_WIDTH-bit word
//   valid_o out  one-cycle strobe, data_o updated this cycle
//   err_o   out  one-cycle strobe, frame bit count != DATA_WIDTH
//   busy_o  out  high while a frame is being received

module spi_slave_i #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  sync_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_WIDTH + 1);
  localparam int AW = $clog2(SYNC_STAGES + 1);
  localparam logic [AW-1:0] ARM_FILL = AW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] sync_sr;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sync_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      sync_sr <= '1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk_i};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi_i};
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], sync_i};
    end
  end

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign sync_s = sync_sr[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Edge detection. The edge flags and the sampled data bit are registered
  // together so the FSM sees each bit exactly in its fall_sclk cycle and the
  // strobe lands SYNC_STAGES+2 cycles after the input is first sampled.
  // ---------------------------------------------------------------------------
  logic prev_sclk;
  logic prev_sync;
  logic fall_sclk;
  logic fall_sync;
  logic rise_sync;
  logic fall_sclk_q;
  logic fall_sync_q;
  logic rise_sync_q;
  logic bit_q;

  assign fall_sclk = prev_sclk & ~sclk_s;
  assign fall_sync = prev_sync & ~sync_s;
  assign rise_sync = ~prev_sync & sync_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_sclk   <= 1'b0;
      prev_sync   <= 1'b1;
      fall_sclk_q <= 1'b0;
      fall_sync_q <= 1'b0;
      rise_sync_q <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      prev_sclk   <= sclk_s;
      prev_sync   <= sync_s;
      fall_sclk_q <= fall_sclk;
      fall_sync_q <= fall_sync;
      rise_sync_q <= rise_sync;
      bit_q       <= mosi_s;
    end
  end

  // ---------------------------------------------------------------------------
  // After reset the sync synchronizer still holds its reset value (1). ARM must
  // not trust sync_s until the chain has been refilled from the pin, otherwise
  // a frame already in progress would be mistaken for an idle bus.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] arm_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_FILL) begin
      arm_cnt <= arm_cnt + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t                state;
  state_t                state_n;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_n;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         cnt_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  valid_n;
  logic                  err_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ARM;
      shift_reg <= '0;
      bit_cnt   <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= cnt_n;
      data_o    <= data_n;
      valid_o   <= valid_n;
      err_o     <= err_n;
      busy_o    <= (state_n == RECV);
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    cnt_n   = bit_cnt;
    data_n  = data_o;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      ARM: begin
        if ((arm_cnt == ARM_FILL) && sync_s) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        // An SCLK fall coinciding with the SYNC fall is not part of the frame.
        if (fall_sync_q) begin
          state_n = RECV;
          shift_n = '0;
          cnt_n   = '0;
        end
      end
      RECV: begin
        // End of frame wins over a simultaneous SCLK fall: judge on the count
        // accumulated before that edge.
        if (rise_sync_q) begin
          state_n = IDLE;
          if (bit_cnt == CNT_FULL) begin
            data_n  = shift_reg;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (fall_sclk_q) begin
          shift_n = {shift_reg[DATA_WIDTH-2:0], bit_q};
          if (bit_cnt != CNT_SAT) begin
            cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = ARM;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_slave_i.sv
// tb/tb_spi_slave_i.sv - self-checking bench for spi_slave_i

module tb_spi_slave_i;

  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int HALF = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          sclk_i;
  logic          mosi_i;
  logic          sync_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          err_o;
  logic          busy_o;

  always #5 clk = ~clk;

  spi_slave_i #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .sclk_i  (sclk_i),
    .mosi_i  (mosi_i),
    .sync_i  (sync_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
  );

  int            total = 0;
  int            bad = 0;
  int            cycle = 0;
  int            valid_cnt = 0;
  int            err_cnt = 0;
  int            last_pulse = 0;
  int            raise_cyc = 0;
  logic          prev_strobe = 1'b0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] model_data = '0;

  typedef struct {
    int          n;
    logic [15:0] v;
    logic        ev;
    logic        ee;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl[5];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_o || err_o) begin
      check("strobe_excl", 32'(valid_o & err_o), 0);
      check("strobe_single", 32'(prev_strobe), 0);
      last_pulse = cycle;
    end
    if (valid_o) begin
      valid_cnt++;
      got_q.push_back(data_o);
    end
    if (err_o) err_cnt++;
    prev_strobe = valid_o | err_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi_i = v[i];
      sclk_i = 1'b1;
      tick(HALF);
      sclk_i = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic send_frame(input logic [15:0] v, input int n, input logic exp_busy);
    sync_i = 1'b0;
    tick(HALF);
    check("busy_in_frame", 32'(busy_o), 32'(exp_busy));
    send_bits(v, n);
    sync_i = 1'b1;
    raise_cyc = cycle;
  endtask

  task automatic run_frame(input logic [15:0] v, input int n, input logic ev, input logic ee,
                           input logic [7:0] ed);
    int vc;
    int ec;
    vc = valid_cnt;
    ec = err_cnt;
    send_frame(v, n, 1'b1);
    tick(12);
    model_data = ed;
    check("valid_count", 32'(valid_cnt - vc), 32'(ev));
    check("err_count", 32'(err_cnt - ec), 32'(ee));
    check("data", 32'(data_o), 32'(model_data));
    check("busy_after", 32'(busy_o), 0);
    if (ev || ee) check("latency", 32'(last_pulse - raise_cyc), 32'(SS + 2));
  endtask

  initial begin
    int            vc;
    int            ec;
    int            n;
    logic [15:0]   v;
    logic          ev;
    logic          busy_seen;

    tbl[0] = '{8, 16'h00A5, 1'b1, 1'b0, 8'hA5};
    tbl[1] = '{7, 16'h0055, 1'b0, 1'b1, 8'hA5};
    tbl[2] = '{9, 16'h01FF, 1'b0, 1'b1, 8'hA5};
    tbl[3] = '{8, 16'h005A, 1'b1, 1'b0, 8'h5A};
    tbl[4] = '{10, 16'h0155, 1'b0, 1'b1, 8'h5A};

    rst_i  = 1'b1;
    sync_i = 1'b1;
    sclk_i = 1'b0;
    mosi_i = 1'b0;
    tick(3);
    check("rst_data", 32'(data_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_i = 1'b0;
    tick(8);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].v, tbl[i].n, tbl[i].ev, tbl[i].ee, tbl[i].ed);
    end

    // back-to-back frames with a 3-cycle SYNC high gap
    vc = valid_cnt;
    ec = err_cnt;
    got_q.delete();
    send_frame(16'h0001, 8, 1'b1);
    tick(3);
    send_frame(16'h00FF, 8, 1'b1);
    tick(12);
    model_data = 8'hFF;
    check("b2b_valid_count", 32'(valid_cnt - vc), 2);
    check("b2b_err_count", 32'(err_cnt - ec), 0);
    check("b2b_queue_size", 32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      check("b2b_first", 32'(got_q[0]), 32'h01);
      check("b2b_second", 32'(got_q[1]), 32'hFF);
    end
    check("b2b_data", 32'(data_o), 32'(model_data));

    // reset in the middle of a frame
    vc = valid_cnt;
    ec = err_cnt;
    sync_i = 1'b0;
    tick(HALF);
    send_bits(16'h000C, 4);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    model_data = '0;
    check("midrst_data", 32'(data_o), 0);
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_valid", 32'(valid_o), 0);
    send_bits(16'h0003, 4);
    sync_i = 1'b1;
    tick(12);
    check("midrst_valid_count", 32'(valid_cnt - vc), 0);
    check("midrst_err_count", 32'(err_cnt - ec), 0);
    check("midrst_data_after", 32'(data_o), 0);
    run_frame(16'h003C, 8, 1'b1, 1'b0, 8'h3C);

    // reset held while SYNC is low: the frame in progress must be ignored
    vc = valid_cnt;
    ec = err_cnt;
    rst_i  = 1'b1;
    sync_i = 1'b0;
    tick(4);
    rst_i = 1'b0;
    model_data = '0;
    tick(HALF);
    send_bits(16'h0077, 8);
    sync_i = 1'b1;
    tick(12);
    check("arm_valid_count", 32'(valid_cnt - vc), 0);
    check("arm_err_count", 32'(err_cnt - ec), 0);
    check("arm_data", 32'(data_o), 0);
    run_frame(16'h0081, 8, 1'b1, 1'b0, 8'h81);

    // SCLK/MOSI activity with SYNC high is ignored
    vc = valid_cnt;
    ec = err_cnt;
    busy_seen = 1'b0;
    repeat (20) begin
      sclk_i = 1'b1;
      mosi_i = ~mosi_i;
      tick(HALF);
      busy_seen |= busy_o;
      sclk_i = 1'b0;
      tick(HALF);
      busy_seen |= busy_o;
    end
    tick(8);
    check("idle_toggle_busy", 32'(busy_seen), 0);
    check("idle_toggle_valid", 32'(valid_cnt - vc), 0);
    check("idle_toggle_err", 32'(err_cnt - ec), 0);
    run_frame(16'h0000, 0, 1'b0, 1'b1, model_data);

    // randomized frames against a frame-level model
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(0, 10);
      if ($urandom_range(0, 1) == 1) n = DW;
      v = 16'($urandom) & ((16'h1 << n) - 16'h1);
      ev = (n == DW);
      run_frame(v, n, ev, !ev, ev ? v[7:0] : model_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
